// File: rtl/lzd_norm_sched.sv
// Two-requester normalizer: round-robin grants one 8-bit operand at a time and
// shifts it left until its MSB is set, sharing a single leading-zero detector.

module lzd8 (
    input  logic [7:0] d,
    output logic [2:0] lz
);
    // The highest set bit wins because it is the last one visited; zero saturates to 7.
    always_comb begin
        lz = 3'd7;
        for (int i = 0; i < 8; i++)
            if (d[i]) lz = 3'(7 - i);
    end
endmodule

module lzd_norm_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_id,
    output logic [7:0] out_mant,
    output logic [2:0] out_lz,
    output logic       out_zero
);
    typedef enum logic [1:0] {IDLE, COUNT, SHIFT, DONE} state_t;

    typedef struct packed {
        logic       id;
        logic [2:0] lz;
        logic       zero;
    } res_t;

    state_t     state, state_nx;
    logic       ptr;
    logic [7:0] opnd;
    logic [2:0] cnt;
    logic [2:0] lz;
    res_t       res;
    logic       win;
    logic       gnt_any;

    lzd8 u_lzd (.d(opnd), .lz(lz));

    // Only contention consults the pointer; a lone requester always wins.
    assign win     = (req0 && req1) ? ptr : req1;
    assign gnt_any = (state == IDLE) && !rst && (req0 || req1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (gnt_any) state_nx = COUNT;
            COUNT: state_nx = (lz == 3'd0 || opnd == 8'h00) ? DONE : SHIFT;
            SHIFT: if (cnt == 3'd1) state_nx = DONE;
            DONE:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt0      = gnt_any && !win;
        gnt1      = gnt_any && win;
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= 1'b0;
            opnd <= 8'h00;
            cnt  <= 3'd0;
            res  <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    opnd   <= win ? data1 : data0;
                    res.id <= win;
                    ptr    <= ~win;
                end
                COUNT: begin
                    cnt      <= lz;
                    res.lz   <= lz;
                    res.zero <= (opnd == 8'h00);
                end
                SHIFT: begin
                    opnd <= {opnd[6:0], 1'b0};
                    cnt  <= cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_mant = opnd;
    assign out_id   = res.id;
    assign out_lz   = res.lz;
    assign out_zero = res.zero;
endmodule

// File: tb/tb_lzd_norm_sched.sv
// Directed bench for lzd_norm_sched: a transaction-level model checked every
// cycle, plus literal expectations for the named scenarios.

module tb_lzd_norm_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       out_ready = 1'b1;
    logic       gnt0, gnt1, busy, out_valid, out_id, out_zero;
    logic [7:0] out_mant;
    logic [2:0] out_lz;

    int n_checks = 0;
    int n_fail   = 0;

    lzd_norm_sched dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_mant(out_mant),
        .out_lz(out_lz), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Normalization from first principles: shift until the MSB is set.
    function automatic void ref_norm(input logic [7:0] d, output logic [7:0] m, output int lz);
        m  = d;
        lz = 0;
        if (d == 8'h00) lz = 7;
        else while (!m[7]) begin
            m = m << 1;
            lz++;
        end
    endfunction

    // Transaction model: one operation in flight, result due 2+n cycles after grant.
    bit         m_busy = 0, m_ptr = 0, m_id = 0, m_zero = 0;
    logic [7:0] m_mant = 8'h00;
    int         m_lz = 0, m_valid_at = 0, cyc = 0;

    initial begin
        @(posedge clk);
        forever begin
            bit e_valid, e_g0, e_g1, w;
            @(negedge clk);
            e_valid = m_busy && (cyc >= m_valid_at);
            e_g0 = 0;
            e_g1 = 0;
            if (!rst && !m_busy && (req0 || req1)) begin
                w = (req0 && req1) ? m_ptr : req1;
                e_g0 = !w;
                e_g1 = w;
            end
            chk("gnt0", gnt0, e_g0);
            chk("gnt1", gnt1, e_g1);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, e_valid);
            if (e_valid) begin
                chk("out_id", out_id, m_id);
                chk("out_mant", out_mant, m_mant);
                chk("out_lz", out_lz, m_lz);
                chk("out_zero", out_zero, m_zero);
            end
            if (rst) begin
                m_busy = 0;
                m_ptr  = 0;
            end else if (e_valid && out_ready) begin
                m_busy = 0;
            end else if (e_g0 || e_g1) begin
                logic [7:0] d;
                d = e_g1 ? data1 : data0;
                ref_norm(d, m_mant, m_lz);
                m_zero     = (d == 8'h00);
                m_id       = e_g1;
                m_ptr      = ~e_g1;
                m_busy     = 1;
                m_valid_at = cyc + 2 + (m_zero ? 0 : m_lz);
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit id);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (id ? gnt1 : gnt0) break;
            step();
        end
        chk("gnt_timeout", k < 40, 1);
    endtask

    // Called one cycle after the grant; lat counts cycles from the grant.
    task automatic wait_valid(output int lat);
        int k;
        lat = 1;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
            step();
            lat++;
        end
        chk("valid_timeout", k < 40, 1);
    endtask

    task automatic single(input bit id, input logic [7:0] d, input int exp_lat,
                          input logic [7:0] exp_m, input int exp_lz, input bit exp_z);
        int lat;
        if (id) begin req1 = 1; data1 = d; end
        else    begin req0 = 1; data0 = d; end
        wait_gnt(id);
        step();
        req0 = 0;
        req1 = 0;
        wait_valid(lat);
        chk("latency", lat, exp_lat);
        chk("lit_mant", out_mant, exp_m);
        chk("lit_lz", out_lz, exp_lz);
        chk("lit_zero", out_zero, exp_z);
        chk("lit_id", out_id, id);
        step();
    endtask

    initial begin
        logic [7:0] pm;
        int         plz, lat, ng, k;
        bit         order [4];

        ref_norm(8'h13, pm, plz);
        chk("model_13_mant", pm, 8'h98);
        chk("model_13_lz", plz, 3);

        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_mant", out_mant, 8'h00);
        chk("rst_lz", out_lz, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_id", out_id, 0);
        step();

        single(0, 8'h13, 5, 8'h98, 3, 0);
        single(1, 8'h00, 2, 8'h00, 7, 1);
        single(0, 8'h01, 9, 8'h80, 7, 0);
        single(0, 8'h80, 2, 8'h80, 0, 0);

        // Contention straight out of reset.
        rst = 1;
        step();
        rst = 0;
        req0 = 1; data0 = 8'h40;
        req1 = 1; data1 = 8'h20;
        ng = 0;
        for (k = 0; k < 80 && ng < 4; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                order[ng] = gnt1;
                ng++;
            end
            step();
        end
        req0 = 0;
        req1 = 0;
        chk("cont_grants", ng, 4);
        chk("cont_order0", order[0], 0);
        chk("cont_order1", order[1], 1);
        chk("cont_order2", order[2], 0);
        chk("cont_order3", order[3], 1);
        wait_valid(lat);
        chk("cont_last_id", out_id, 1);
        step();

        // Backpressure with a request pending behind the held result.
        out_ready = 0;
        req0 = 1; data0 = 8'h80;
        wait_gnt(0);
        step();
        req0 = 0;
        req1 = 1; data1 = 8'h04;
        wait_valid(lat);
        repeat (5) begin
            step();
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_nognt", gnt1, 0);
            chk("bp_mant", out_mant, 8'h80);
            chk("bp_lz", out_lz, 0);
        end
        step();
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 1);
        chk("bp_release_nognt", gnt1, 0);
        step();
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_next_gnt", gnt1, 1);
        step();
        req1 = 0;
        wait_valid(lat);
        chk("bp_next_lat", lat, 7);
        chk("bp_next_mant", out_mant, 8'h80);
        chk("bp_next_lz", out_lz, 5);
        step();

        // Reset while shifting 0x01, after a grant that left the pointer at 1.
        req0 = 1; data0 = 8'h01;
        wait_gnt(0);
        step();
        req0 = 0;
        step();
        @(negedge clk);
        chk("shift_busy", busy, 1);
        step();
        rst = 1;
        req0 = 1; data0 = 8'h55;
        req1 = 1; data1 = 8'hAA;
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_gnt0", gnt0, 1);
        chk("abort_gnt1", gnt1, 0);
        step();
        req0 = 0;
        wait_valid(lat);
        chk("abort_next_lat", lat, 3);
        chk("abort_next_mant", out_mant, 8'hAA);
        step();
        wait_gnt(1);
        step();
        req1 = 0;
        wait_valid(lat);
        chk("last_lat", lat, 2);
        chk("last_id", out_id, 1);
        step();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
